// File: rtl/control_sequencer_pkg.sv
// Shared LEGv8 control definitions: opcodes, FS/PS encodings, instruction
// field positions, control-word layout and sequencer state/class enums.
package control_sequencer_pkg;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BRANCH} state_e;
  typedef enum logic [1:0] {CLS_SEQ, CLS_CB, CLS_ILL} cls_e;

  // Packed so that ps lands on [30:29] and sl on [0] of controlWord
  typedef struct packed {
    logic [1:0] ps;
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] fs;
    logic       reg_w;
    logic       ram_w;
    logic       en_mem;
    logic       en_alu;
    logic       en_b;
    logic       en_pc;
    logic       sel_b;
    logic       pc_sel;
    logic       sl;
  } cw_t;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_A    = 2'b11;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01010;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  localparam logic [9:0]  OP_EORI = 10'b1101001000;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;

  localparam int RD_LSB = 0;
  localparam int RN_LSB = 5;
  localparam int RM_LSB = 16;

  localparam int XZR = 31;

endpackage

// File: rtl/control_decoder.sv
// Combinational LEGv8 decode: instruction word to control word, immediate and class.
// LSL/LSR decode only when CONTROL_SEQUENCER_SHIFT_EN is defined.
module control_decoder
  import control_sequencer_pkg::*;
(
  input  logic [31:0] instr_i,
  output cw_t         cw_o,
  output logic [63:0] k_o,
  output cls_e        cls_o
);

  logic [4:0] rd, rn, rm;
  assign rd = instr_i[RD_LSB +: 5];
  assign rn = instr_i[RN_LSB +: 5];
  assign rm = instr_i[RM_LSB +: 5];

  always_comb begin
    cw_o  = '0;
    k_o   = '0;
    cls_o = CLS_SEQ;
    if (instr_i[31:26] == OP_B) begin
      cw_o.ps = PS_BR;
      k_o     = {{38{instr_i[25]}}, instr_i[25:0]};
    end else if (instr_i[31:24] == OP_CBZ || instr_i[31:24] == OP_CBNZ) begin
      // Pass Rt through the ALU (XZR | Rt) so Zero reflects Rt == 0
      cls_o   = CLS_CB;
      cw_o.sa = 5'(XZR);
      cw_o.sb = rd;
      cw_o.fs = FS_OR;
      cw_o.ps = PS_HOLD;
    end else begin
      case (instr_i[31:22])
        OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI: begin
          cw_o.da     = rd;
          cw_o.sa     = rn;
          cw_o.sel_b  = 1'b1;
          cw_o.reg_w  = 1'b1;
          cw_o.en_alu = 1'b1;
          cw_o.ps     = PS_INC;
          k_o         = {52'd0, instr_i[21:10]};
          case (instr_i[31:22])
            OP_SUBI: cw_o.fs = FS_SUB;
            OP_ANDI: cw_o.fs = FS_AND;
            OP_ORRI: cw_o.fs = FS_OR;
            OP_EORI: cw_o.fs = FS_XOR;
            default: cw_o.fs = FS_ADD;
          endcase
        end
        default: begin
          case (instr_i[31:21])
            OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR: begin
              cw_o.da     = rd;
              cw_o.sa     = rn;
              cw_o.sb     = rm;
              cw_o.reg_w  = 1'b1;
              cw_o.en_alu = 1'b1;
              cw_o.ps     = PS_INC;
              case (instr_i[31:21])
                OP_SUB:  cw_o.fs = FS_SUB;
                OP_AND:  cw_o.fs = FS_AND;
                OP_ORR:  cw_o.fs = FS_OR;
                OP_EOR:  cw_o.fs = FS_XOR;
                default: cw_o.fs = FS_ADD;
              endcase
            end
            OP_LDUR: begin
              cw_o.da     = rd;
              cw_o.sa     = rn;
              cw_o.fs     = FS_ADD;
              cw_o.sel_b  = 1'b1;
              cw_o.reg_w  = 1'b1;
              cw_o.en_mem = 1'b1;
              cw_o.ps     = PS_INC;
              k_o         = {{55{instr_i[20]}}, instr_i[20:12]};
            end
            OP_STUR: begin
              cw_o.sa    = rn;
              cw_o.sb    = rd;
              cw_o.fs    = FS_ADD;
              cw_o.sel_b = 1'b1;
              cw_o.ram_w = 1'b1;
              cw_o.en_b  = 1'b1;
              cw_o.ps    = PS_INC;
              k_o        = {{55{instr_i[20]}}, instr_i[20:12]};
            end
`ifdef CONTROL_SEQUENCER_SHIFT_EN
            OP_LSL, OP_LSR: begin
              cw_o.da     = rd;
              cw_o.sa     = rn;
              cw_o.sel_b  = 1'b1;
              cw_o.reg_w  = 1'b1;
              cw_o.en_alu = 1'b1;
              cw_o.ps     = PS_INC;
              cw_o.fs     = (instr_i[31:21] == OP_LSL) ? FS_LSL : FS_LSR;
              k_o         = {58'd0, instr_i[15:10]};
            end
`endif
            default: cls_o = CLS_ILL;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// LEGv8 control sequencer: IDLE/EXEC/BRANCH FSM, registered control word and
// retired counter. Define CONTROL_SEQUENCER_SHIFT_EN to decode LSL/LSR.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        instrValid,
  output logic        instrReady,
  input  logic [4:0]  status,
  output logic [30:0] controlWord,
  output logic [63:0] K,
  output logic        illegal,
  output logic [15:0] retired
);

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d, dec_cls;
  cw_t         cw_q, cw_d, dec_cw;
  logic [63:0] k_q, k_d, dec_k;
  logic [19:0] ir_q, ir_d;      // instruction[24:5]: CBNZ bit + imm19
  logic        ill_q, ill_d;
  logic [15:0] ret_q, ret_d;
  logic        taken;
  logic        unused_status;

  assign unused_status = ^status[4:1];

  control_decoder u_dec (
    .instr_i (instruction),
    .cw_o    (dec_cw),
    .k_o     (dec_k),
    .cls_o   (dec_cls)
  );

  // CBZ (bit24=0) takes on Zero=1, CBNZ (bit24=1) on Zero=0
  assign taken = status[0] ^ ir_q[19];

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    ir_d    = ir_q;
    cw_d    = '0;
    k_d     = '0;
    ill_d   = 1'b0;
    ret_d   = ret_q;
    case (state_q)
      S_IDLE: begin
        if (instrValid) begin
          state_d = S_EXEC;
          ir_d    = instruction[24:5];
          cls_d   = dec_cls;
          ill_d   = (dec_cls == CLS_ILL);
          if (dec_cls != CLS_ILL) begin
            cw_d = dec_cw;
            k_d  = dec_k;
          end
        end
      end
      S_EXEC: begin
        if (cls_q == CLS_CB) begin
          state_d = S_BRANCH;
          cw_d.ps = taken ? PS_BR : PS_INC;
          k_d     = taken ? {{45{ir_q[18]}}, ir_q[18:0]} : 64'd0;
        end else begin
          state_d = S_IDLE;
          if (cls_q != CLS_ILL) ret_d = ret_q + 16'd1;
        end
      end
      S_BRANCH: begin
        state_d = S_IDLE;
        ret_d   = ret_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cls_q   <= CLS_SEQ;
      ir_q    <= '0;
      cw_q    <= '0;
      k_q     <= '0;
      ill_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      ir_q    <= ir_d;
      cw_q    <= cw_d;
      k_q     <= k_d;
      ill_q   <= ill_d;
      ret_q   <= ret_d;
    end
  end

  assign instrReady  = (state_q == S_IDLE);
  assign controlWord = cw_q;
  assign K           = k_q;
  assign illegal     = ill_q;
  assign retired     = ret_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with hand-computed control-word fields.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        instrValid;
  logic        instrReady;
  logic [4:0]  status;
  logic [30:0] controlWord;
  logic [63:0] K;
  logic        illegal;
  logic [15:0] retired;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_ret  = 0;

  control_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .instrValid  (instrValid),
    .instrReady  (instrReady),
    .status      (status),
    .controlWord (controlWord),
    .K           (K),
    .illegal     (illegal),
    .retired     (retired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] w);
    instruction = w;
    instrValid  = 1'b1;
    step();
    instrValid  = 1'b0;
  endtask

  function automatic logic [1:0] f_ps();  return controlWord[30:29]; endfunction
  function automatic logic [4:0] f_da();  return controlWord[28:24]; endfunction
  function automatic logic [4:0] f_sa();  return controlWord[23:19]; endfunction
  function automatic logic [4:0] f_sb();  return controlWord[18:14]; endfunction
  function automatic logic [4:0] f_fs();  return controlWord[13:9];  endfunction

  initial begin
    reset = 1'b0; instruction = '0; instrValid = 1'b0; status = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_cw", 64'(controlWord), 64'd0);
    chk("rst_k", K, 64'd0);
    chk("rst_ill", 64'(illegal), 64'd0);
    chk("rst_ret", 64'(retired), 64'd0);
    reset = 1'b1;
    step();
    chk("rst_ready", 64'(instrReady), 64'd1);

    // ADDI X5,XZR,#24
    issue(32'h910063E5);
    chk("addi_ready", 64'(instrReady), 64'd0);
    chk("addi_da", 64'(f_da()), 64'd5);
    chk("addi_sa", 64'(f_sa()), 64'd31);
    chk("addi_fs", 64'(f_fs()), 64'h08);
    chk("addi_selb", 64'(controlWord[2]), 64'd1);
    chk("addi_regw", 64'(controlWord[8]), 64'd1);
    chk("addi_ps", 64'(f_ps()), 64'd1);
    chk("addi_k", K, 64'd24);
    step(); exp_ret++;
    chk("addi_ret", 64'(retired), 64'(exp_ret));
    chk("addi_idle_cw", 64'(controlWord), 64'd0);
    chk("addi_idle_ready", 64'(instrReady), 64'd1);

    // ADD X1,X5,X7 then EOR X30,X1,X5
    issue(32'h8B0700A1);
    chk("add_fs", 64'(f_fs()), 64'h08);
    chk("add_da", 64'(f_da()), 64'd1);
    chk("add_sa", 64'(f_sa()), 64'd5);
    chk("add_sb", 64'(f_sb()), 64'd7);
    chk("add_selb", 64'(controlWord[2]), 64'd0);
    chk("add_enalu", 64'(controlWord[5]), 64'd1);
    step(); exp_ret++;
    issue(32'hCA05003E);
    chk("eor_fs", 64'(f_fs()), 64'h0C);
    chk("eor_da", 64'(f_da()), 64'd30);
    step(); exp_ret++;
    chk("eor_ret", 64'(retired), 64'(exp_ret));

    // CBZ X3,#-2 taken
    issue(32'hB4FFFFC3);
    chk("cbz_ex_sa", 64'(f_sa()), 64'd31);
    chk("cbz_ex_sb", 64'(f_sb()), 64'd3);
    chk("cbz_ex_fs", 64'(f_fs()), 64'h04);
    chk("cbz_ex_ps", 64'(f_ps()), 64'd0);
    chk("cbz_ex_selb", 64'(controlWord[2]), 64'd0);
    status = 5'b00001;
    step();
    status = 5'b00000;
    chk("cbz_t_ps", 64'(f_ps()), 64'd2);
    chk("cbz_t_k", K, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("cbz_t_ready", 64'(instrReady), 64'd0);
    chk("cbz_t_ret_hold", 64'(retired), 64'(exp_ret));
    step(); exp_ret++;
    chk("cbz_t_ret", 64'(retired), 64'(exp_ret));

    // CBZ X3,#-2 not taken
    issue(32'hB4FFFFC3);
    status = 5'b00000;
    step();
    chk("cbz_n_ps", 64'(f_ps()), 64'd1);
    step(); exp_ret++;
    chk("cbz_n_ret", 64'(retired), 64'(exp_ret));

    // B #-1
    issue(32'h17FFFFFF);
    chk("b_ps", 64'(f_ps()), 64'd2);
    chk("b_k", K, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("b_regw", 64'(controlWord[8]), 64'd0);
    step(); exp_ret++;

    // LDUR X2,[X4,#-8]
    issue(32'hF85F8082);
    chk("ldur_da", 64'(f_da()), 64'd2);
    chk("ldur_sa", 64'(f_sa()), 64'd4);
    chk("ldur_fs", 64'(f_fs()), 64'h08);
    chk("ldur_mem", 64'(controlWord[6]), 64'd1);
    chk("ldur_k", K, 64'hFFFF_FFFF_FFFF_FFF8);
    step(); exp_ret++;
    chk("ldur_ret", 64'(retired), 64'(exp_ret));

    // Undecodable word
    issue(32'h00000000);
    chk("ill_pulse", 64'(illegal), 64'd1);
    chk("ill_cw", 64'(controlWord), 64'd0);
    chk("ill_k", K, 64'd0);
    step();
    chk("ill_clear", 64'(illegal), 64'd0);
    chk("ill_ret", 64'(retired), 64'(exp_ret));

    // LSL X17,X30,#2
    issue(32'hD3600BD1);
`ifdef CONTROL_SEQUENCER_SHIFT_EN
    chk("lsl_fs", 64'(f_fs()), 64'h10);
    chk("lsl_k", K, 64'd2);
    chk("lsl_da", 64'(f_da()), 64'd17);
    chk("lsl_ill", 64'(illegal), 64'd0);
    step(); exp_ret++;
`else
    chk("lsl_ill", 64'(illegal), 64'd1);
    chk("lsl_cw", 64'(controlWord), 64'd0);
    step();
`endif
    chk("lsl_ret", 64'(retired), 64'(exp_ret));

    // Reset asserted mid-EXEC
    issue(32'h8B0700A1);
    reset = 1'b0;
    #1;
    chk("rexec_cw", 64'(controlWord), 64'd0);
    chk("rexec_k", K, 64'd0);
    chk("rexec_ret", 64'(retired), 64'd0);
    chk("rexec_ready", 64'(instrReady), 64'd1);
    step();
    reset = 1'b1;
    step();
    issue(32'h910063E5);
    chk("post_rst_da", 64'(f_da()), 64'd5);
    step();
    chk("post_rst_ret", 64'(retired), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
